ex_issue: RTL and testbench
===========================

# ex_issue

Execute-stage issue/collect register for the s3_execute datapath. Accepts one decoded operation per cycle from the s2 decode stage over a valid/ready handshake and decodes the op select into one-hot enables for the gated op units (add, sub, xor, or, and, sll, srl, sra, slt, sltu, eq, ge, geu). It OR-reduces the gated results, resolves branch outcomes and registers the outcome into the EX/MEM pipeline slot. Backpressure from the memory stage stalls the slot without losing or duplicating operations.

## Interface
- XLEN, 32, datapath width; only 32 is supported
- RD_W, 5, destination register index width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  s2 presents an operation
- in_ready  out  1  slot can accept this cycle
- in_op  in  4  op select: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 eq, 11 ge, 12 geu, 13-15 illegal
- in_a, in_b  in  XLEN  operands
- in_rd  in  RD_W  destination register
- in_br  in  1  operation is a branch compare (ops 10-12 only)
- in_inv  in  1  invert the compare outcome (bne/blt/bltu)
- flush  in  1  discard the held and incoming operation
- op_en  out  13  one-hot enables to the op units, bit index = in_op
- op_a, op_b  out  XLEN  operands to the op units (pass-through of in_a/in_b)
- op_res  in  13×XLEN  gated results from the op units, packed, unit k at [k*XLEN +: XLEN]
- out_valid  out  1  EX/MEM slot holds a result
- out_ready  in  1  memory stage consumes the slot
- out_result  out  XLEN  registered ALU result (0 for branches)
- out_rd  out  RD_W  registered destination (0 for branches)
- out_wb  out  1  register write-back required
- out_taken  out  1  branch taken
- out_illegal  out  1  op select was 13-15

## Operation
- Accept condition: fire = in_valid && in_ready && !flush; in_ready = !out_valid || out_ready (combinational).
- op_en = one-hot(in_op) when in_valid && in_ready, else all zero; op_en is 0 for in_op ≥ 13.
- Combinational result r = OR of all 13 slices of op_res; since at most one unit is enabled, r equals the selected unit's output.
- On fire, load the slot:
  - non-branch legal op: out_result = r, out_rd = in_rd, out_wb = (in_rd != 0), out_taken = 0.
  - branch (in_br=1, in_op ∈ {10,11,12}): out_taken = r[0] XOR in_inv, out_result = 0, out_rd = 0, out_wb = 0.
  - in_br=1 with in_op ∉ {10,11,12}, or in_op ≥ 13: out_illegal = 1, out_wb = 0, out_taken = 0, out_result = 0.
- Slot state: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on fire.
  - FULL → FULL (reload) on fire with out_ready=1; FULL → EMPTY on out_ready=1 without fire.
  - FULL holds all out_* stable while out_ready=0.
- flush: next cycle out_valid=0 regardless of out_ready or in_valid; no op_en asserted in a flush cycle.
- Shift ops use b[4:0] only (enforced by the op units); slt/sltu/eq/ge/geu return 0 or 1 in bit 0.

## Timing
- Latency: 1 cycle from fire to out_valid; throughput 1 op/cycle while out_ready=1.
- Reset (rst_n=0 at a rising edge): out_valid=0, out_result=0, out_rd=0, out_wb=0, out_taken=0, out_illegal=0; in_ready=1 and op_en=0 in the first cycle after release.
- Reset mid-stall: any held result is dropped; no output pulses during reset.
- Simultaneous flush and fire request: flush wins, the input is not accepted (in_ready may be 1 but the op is lost by contract; s2 is flushed too).
- Simultaneous out_ready and in_valid while FULL: consume and reload in the same edge; no bubble.
- Outputs are registered; no combinational path from op_res to out_*.

## Test plan
- Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, all out_* = 0, op_en=0; after release in_ready=1.
- Back-to-back ALU: add 5+7, sub 3-5, sra 0x80000000>>4 with out_ready=1 -> out_result 12, 0xFFFFFFFE, 0xF8000000 on 3 consecutive cycles, out_wb=1.
- Branch: eq 9,9 in_inv=0 -> out_taken=1, out_wb=0; ge -1,0 in_inv=0 -> out_taken=0; geu 1,2 in_inv=1 (bltu) -> out_taken=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after the first accept, out_result stable, op_en=0; release -> next op delivered exactly once.
- Flush: FULL slot with out_ready=0, pulse flush -> out_valid=0 next cycle, pending input not accepted.
- Illegal/rd0: in_op=14 -> out_illegal=1, out_wb=0; add with in_rd=0 -> out_wb=0, out_result still correct.

Source files
------------

// File: rtl/ex_issue.sv
// ex_issue: EX issue/collect slot; s2 valid/ready in, one-hot op_en and op_a/op_b out to the op units, op_res back in, registered EX/MEM slot out with out_valid/out_ready
module ex_issue #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [XLEN-1:0]    in_a,
  input  logic [XLEN-1:0]    in_b,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               in_br,
  input  logic               in_inv,
  input  logic               flush,
  output logic [12:0]        op_en,
  output logic [XLEN-1:0]    op_a,
  output logic [XLEN-1:0]    op_b,
  input  logic [13*XLEN-1:0] op_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RD_W-1:0]    out_rd,
  output logic               out_wb,
  output logic               out_taken,
  output logic               out_illegal
);
  logic            fire;
  logic            cmp_op;
  logic            ill;
  logic [XLEN-1:0] r;
  assign in_ready = !out_valid || out_ready;
  assign fire     = rst_n && in_valid && in_ready && !flush;
  assign op_en    = (fire && in_op < 4'd13) ? 13'd1 << in_op : 13'd0;
  assign op_a     = in_a;
  assign op_b     = in_b;
  assign cmp_op   = in_op inside {4'd10, 4'd11, 4'd12};
  assign ill      = in_op > 4'd12 || (in_br && !cmp_op);
  always_comb begin
    r = '0;
    for (int k = 0; k < 13; k++) r |= op_res[k*XLEN +: XLEN];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_wb      <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_illegal <= ill;
      out_taken   <= !ill && in_br && (r[0] ^ in_inv);
      out_result  <= (ill || in_br) ? '0 : r;
      out_rd      <= (ill || in_br) ? '0 : in_rd;
      out_wb      <= !ill && !in_br && in_rd != '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_issue.sv
// tb_ex_issue: scoreboard bench for ex_issue with a behavioural model of the gated op units
module tb_ex_issue;
  logic          clk = 0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [4:0]    in_rd;
  logic          in_br;
  logic          in_inv;
  logic          flush;
  logic [12:0]   op_en;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [415:0]  op_res;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [4:0]    out_rd;
  logic          out_wb;
  logic          out_taken;
  logic          out_illegal;
  int            total = 0;
  int            bad = 0;
  int            ncons = 0;
  bit            mon = 0;
  bit            rnd = 0;
  logic [39:0]   q[$];
  ex_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_br(in_br), .in_inv(in_inv), .flush(flush),
    .op_en(op_en), .op_a(op_a), .op_b(op_b), .op_res(op_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wb(out_wb),
    .out_taken(out_taken), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a ^ b;
      4'd3:  return a | b;
      4'd4:  return a & b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return {31'd0, $signed(a) < $signed(b)};
      4'd9:  return {31'd0, a < b};
      4'd10: return {31'd0, a == b};
      4'd11: return {31'd0, $signed(a) >= $signed(b)};
      4'd12: return {31'd0, a >= b};
      default: return 32'd0;
    endcase
  endfunction
  always_comb begin
    op_res = '0;
    for (int k = 0; k < 13; k++) if (op_en[k]) op_res[k*32 +: 32] = alu(4'(k), op_a, op_b);
  end
  function automatic logic [39:0] exp_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] rd, input logic br, input logic inv);
    logic [31:0] r;
    r = alu(op, a, b);
    if (op > 4'd12 || (br && !(op inside {4'd10, 4'd11, 4'd12}))) return {32'd0, 5'd0, 1'b0, 1'b0, 1'b1};
    if (br) return {32'd0, 5'd0, 1'b0, r[0] ^ inv, 1'b0};
    return {r, rd, rd != 5'd0, 1'b0, 1'b0};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask
  always @(negedge clk) if (mon) begin
    logic mready;
    logic [12:0] en;
    mready = q.size() == 0 || out_ready;
    en = (rst_n && in_valid && mready && !flush && in_op < 4'd13) ? 13'd1 << in_op : 13'd0;
    chk("op_en", op_en, en);
    if (!rst_n) q.delete();
    else begin
      chk("in_ready", in_ready, mready);
      chk("op_a", op_a, in_a);
      chk("op_b", op_b, in_b);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("slot", {out_result, out_rd, out_wb, out_taken, out_illegal}, q[0]);
        if (out_ready) begin
          void'(q.pop_front());
          ncons++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && mready) q.push_back(exp_of(in_op, in_a, in_b, in_rd, in_br, in_inv));
    end
  end
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic br, input logic inv, input logic fl);
    int n = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_rd = rd; in_br = br; in_inv = inv; flush = fl;
    forever begin
      @(negedge clk);
      if (fl || in_ready) break;
      if (++n > 50) begin
        chk("timeout", in_ready, 1);
        break;
      end
      @(posedge clk); #1;
      if (rnd) out_ready = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
  endtask
  initial begin
    int n0;
    rst_n = 0; in_valid = 1; in_op = 0; in_a = 1; in_b = 2; in_rd = 3; in_br = 0; in_inv = 0;
    flush = 0; out_ready = 1;
    @(posedge clk); #1;
    mon = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {out_result, out_rd, out_wb, out_taken, out_illegal}, 0);
    chk("rst_op_en", op_en, 0);
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    chk("rel_op_en", op_en, 0);
    @(posedge clk); #1;
    send(4'd0, 32'd5, 32'd7, 5'd1, 0, 0, 0);
    send(4'd1, 32'd3, 32'd5, 5'd2, 0, 0, 0);
    send(4'd7, 32'h8000_0000, 32'd4, 5'd3, 0, 0, 0);
    send(4'd10, 32'd9, 32'd9, 5'd4, 1, 0, 0);
    send(4'd11, 32'hFFFF_FFFF, 32'd0, 5'd5, 1, 0, 0);
    send(4'd12, 32'd1, 32'd2, 5'd6, 1, 1, 0);
    send(4'd14, 32'd1, 32'd2, 5'd7, 0, 0, 0);
    send(4'd2, 32'd1, 32'd2, 5'd8, 1, 0, 0);
    send(4'd0, 32'd40, 32'd2, 5'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 0;
    send(4'd0, 32'd1, 32'd2, 5'd9, 0, 0, 0);
    in_valid = 1; in_op = 4'd2; in_a = 32'hF0F0; in_b = 32'h0FF0; in_rd = 5'd10;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    n0 = ncons;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_once", ncons - n0, 2);
    chk("bp_empty", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 0;
    send(4'd3, 32'h10, 32'h01, 5'd11, 0, 0, 0);
    send(4'd4, 32'hFF, 32'h0F, 5'd12, 0, 0, 1);
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_drop", q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1;
    rnd = 1;
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic br;
      op = 4'($urandom_range(0, 15));
      br = (op inside {4'd10, 4'd11, 4'd12}) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      send(op, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           5'($urandom_range(0, 31)), br, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    rnd = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst2_valid", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
